// File: rtl/goertzel_tone_detect_pkg.sv
// Shared encodings for the Goertzel tone detector: tone classes, ASCII report
// characters and the UART feeder state machine.
package goertzel_tone_detect_pkg;

  typedef enum logic [1:0] {
    TONE_NONE = 2'b00,
    TONE_BIN0 = 2'b01,
    TONE_BIN1 = 2'b10
  } tone_t;

  localparam logic [7:0] CH_NONE = 8'h2D;
  localparam logic [7:0] CH_BIN0 = 8'h30;
  localparam logic [7:0] CH_BIN1 = 8'h31;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_t;

  function automatic logic [7:0] tone_char(input tone_t t);
    case (t)
      TONE_BIN0: tone_char = CH_BIN0;
      TONE_BIN1: tone_char = CH_BIN1;
      default:   tone_char = CH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/goertzel_uart_feeder.sv
// UART byte feeder: TX handshake FSM plus single-entry pending byte, or a
// 5-byte magnitude record buffer when GOERTZEL_DBG_MAG_EN is defined.
module goertzel_uart_feeder
  import goertzel_tone_detect_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_busy_i,
`ifdef GOERTZEL_DBG_MAG_EN
  input  logic        frame_i,
  input  logic [15:0] g0_i,
  input  logic [15:0] g1_i,
  input  logic [7:0]  char_i,
`else
  input  logic        push_i,
  input  logic [7:0]  byte_i,
`endif
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o
);

  tx_state_t  state_q;
  logic [7:0] tx_data_q;
  logic       tx_start_q;
  logic       have_byte;
  logic [7:0] next_byte;
  logic       pop;

`ifdef GOERTZEL_DBG_MAG_EN
  logic [39:0] rec_q;
  logic [2:0]  rec_cnt_q;

  assign have_byte = (rec_cnt_q != 3'd0);
  assign next_byte = rec_q[39:32];
`else
  logic [7:0] pend_q;
  logic       pend_valid_q;

  assign have_byte = pend_valid_q;
  assign next_byte = pend_q;
`endif

  assign pop = (state_q == TX_IDLE) && have_byte && !tx_busy_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= TX_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef GOERTZEL_DBG_MAG_EN
      rec_q      <= '0;
      rec_cnt_q  <= '0;
`else
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (pop) begin
            state_q    <= TX_START;
            tx_start_q <= 1'b1;
            tx_data_q  <= next_byte;
          end
        end
        TX_START: begin
          tx_start_q <= 1'b0;
          state_q    <= TX_WAIT_HI;
        end
        TX_WAIT_HI: if (tx_busy_i) state_q <= TX_WAIT_LO;
        TX_WAIT_LO: if (!tx_busy_i) state_q <= TX_IDLE;
        default:    state_q <= TX_IDLE;
      endcase
`ifdef GOERTZEL_DBG_MAG_EN
      // A record is in flight until its last byte has fully left the FSM.
      if (pop) begin
        rec_q     <= {rec_q[31:0], 8'h00};
        rec_cnt_q <= rec_cnt_q - 3'd1;
      end else if (frame_i && rec_cnt_q == 3'd0 && state_q == TX_IDLE) begin
        rec_q     <= {g0_i, g1_i, char_i};
        rec_cnt_q <= 3'd5;
      end
`else
      // A push in the same cycle as a pop keeps the entry full with the new byte.
      if (push_i) begin
        pend_q       <= byte_i;
        pend_valid_q <= 1'b1;
      end else if (pop) begin
        pend_valid_q <= 1'b0;
      end
`endif
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;

endmodule

// File: rtl/goertzel_tone_detect.sv
// Two-bin tone classifier with debounce feeding a UART reporter.
// Optional magnitude record reporting via GOERTZEL_DBG_MAG_EN.
module goertzel_tone_detect
  import goertzel_tone_detect_pkg::*;
#(
  parameter logic [15:0] MIN_MAG  = 16'd256,
  parameter logic [15:0] MARGIN   = 16'd128,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] G0,
  input  logic [15:0] G1,
  input  logic        G_READY,
  input  logic        tx_busy,
  output logic [1:0]  tone,
  output logic        tone_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic [15:0] g0_q, g1_q;
  logic        frame_q;
  tone_t       prev_q, tone_q;
  logic [3:0]  run_q;
  logic        tone_valid_q;

  tone_t       cls, tone_d;
  logic [3:0]  run_d;
  logic        change;

  always_comb begin
    cls = TONE_NONE;
    if (g0_q >= MIN_MAG && {1'b0, g0_q} > ({1'b0, g1_q} + {1'b0, MARGIN}))
      cls = TONE_BIN0;
    else if (g1_q >= MIN_MAG && {1'b0, g1_q} > ({1'b0, g0_q} + {1'b0, MARGIN}))
      cls = TONE_BIN1;
    run_d  = (cls == prev_q) ? ((run_q == 4'hF) ? run_q : run_q + 4'd1) : 4'd1;
    change = frame_q && (run_d == DEB) && (cls != tone_q);
    tone_d = change ? cls : tone_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      g0_q         <= '0;
      g1_q         <= '0;
      frame_q      <= 1'b0;
      prev_q       <= TONE_NONE;
      tone_q       <= TONE_NONE;
      run_q        <= '0;
      tone_valid_q <= 1'b0;
    end else begin
      frame_q <= G_READY;
      if (G_READY) begin
        g0_q <= G0;
        g1_q <= G1;
      end
      tone_valid_q <= change;
      if (frame_q) begin
        prev_q <= cls;
        run_q  <= run_d;
        tone_q <= tone_d;
      end
    end
  end

  assign tone       = tone_q;
  assign tone_valid = tone_valid_q;

`ifdef GOERTZEL_DBG_MAG_EN
  // The record's trailing character reports the debounced tone after this frame.
  goertzel_uart_feeder u_feeder (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .tx_busy_i  (tx_busy),
    .frame_i    (frame_q),
    .g0_i       (g0_q),
    .g1_i       (g1_q),
    .char_i     (tone_char(tone_d)),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start)
  );
`else
  goertzel_uart_feeder u_feeder (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .tx_busy_i  (tx_busy),
    .push_i     (change),
    .byte_i     (tone_char(cls)),
    .tx_data_o  (tx_data),
    .tx_start_o (tx_start)
  );
`endif

endmodule

// File: tb/tb_goertzel_tone_detect.sv
// Self-checking bench for goertzel_tone_detect: frame table with tone checks
// and a byte scoreboard fed by a simple UART busy model.
module tb_goertzel_tone_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] g0, g1;
  logic        grdy;
  logic        force_busy, uart_en;
  logic [2:0]  busy_cnt;
  logic        tx_busy;
  logic [1:0]  tone;
  logic        tone_valid;
  logic [7:0]  tx_data;
  logic        tx_start;

  int          vec_cnt   = 0;
  int          err_cnt   = 0;
  int          start_cnt = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  goertzel_tone_detect #(
    .MIN_MAG (16'd256),
    .MARGIN  (16'd128),
    .DEBOUNCE(3)
  ) dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .G0        (g0),
    .G1        (g1),
    .G_READY   (grdy),
    .tx_busy   (tx_busy),
    .tone      (tone),
    .tone_valid(tone_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start)
  );

  // UART model: busy for four cycles after each accepted start strobe.
  always_ff @(posedge clk) begin
    if (rst) busy_cnt <= '0;
    else if (tx_start && uart_en) busy_cnt <= 3'd4;
    else if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
  end
  assign tx_busy = force_busy | (busy_cnt != 3'd0);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && tx_start) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL tx_unexpected: got byte %0h, want no transmission", tx_data);
      end else begin
        chk("tx_byte", {8'h00, tx_data}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [7:0] ch(input logic [1:0] t);
    case (t)
      2'b01:   ch = 8'h30;
      2'b10:   ch = 8'h31;
      default: ch = 8'h2D;
    endcase
  endfunction

  // Returns on the falling edge after the capture edge.
  task automatic frame(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    g0 = a; g1 = b; grdy = 1'b1;
    @(negedge clk);
    grdy = 1'b0;
    g0 = 16'($urandom);
    g1 = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] g0;
    logic [15:0] g1;
    logic [1:0]  tone;
    logic        valid;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    bit seen;
    tbl[0]  = '{16'd300,   16'd200,   2'b00, 1'b0};
    tbl[1]  = '{16'd200,   16'd0,     2'b00, 1'b0};
    tbl[2]  = '{16'd255,   16'd0,     2'b00, 1'b0};
    tbl[3]  = '{16'd256,   16'd128,   2'b00, 1'b0};
    tbl[4]  = '{16'hFFFF,  16'hFFF0,  2'b00, 1'b0};
    tbl[5]  = '{16'd1000,  16'd100,   2'b00, 1'b0};
    tbl[6]  = '{16'd1000,  16'd100,   2'b00, 1'b0};
    tbl[7]  = '{16'd1000,  16'd100,   2'b01, 1'b1};
    tbl[8]  = '{16'd100,   16'd1000,  2'b01, 1'b0};
    tbl[9]  = '{16'd0,     16'd384,   2'b01, 1'b0};
    tbl[10] = '{16'd257,   16'd128,   2'b01, 1'b0};
    tbl[11] = '{16'd100,   16'd1000,  2'b01, 1'b0};
    tbl[12] = '{16'd0,     16'd384,   2'b01, 1'b0};
    tbl[13] = '{16'd100,   16'd1000,  2'b10, 1'b1};

    rst = 1'b1; g0 = '0; g1 = '0; grdy = 1'b0;
    force_busy = 1'b0; uart_en = 1'b1;
    idle(3);
    chk("rst_tone", {14'd0, tone}, 16'd0);
    chk("rst_tone_valid", {15'd0, tone_valid}, 16'd0);
    chk("rst_tx_start", {15'd0, tx_start}, 16'd0);
    chk("rst_tx_data", {8'd0, tx_data}, 16'd0);
    rst = 1'b0;
    idle(2);

`ifdef GOERTZEL_DBG_MAG_EN
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h2D);
    frame(16'h1234, 16'h0056);
    @(negedge clk);
    chk("dbg_tone", {14'd0, tone}, 16'd0);
    idle(80);
    chk("dbg_tx_count", 16'(start_cnt), 16'd5);
`else
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].valid) exp_q.push_back(ch(tbl[i].tone));
      frame(tbl[i].g0, tbl[i].g1);
      @(negedge clk);
      chk($sformatf("tone[%0d]", i), {14'd0, tone}, {14'd0, tbl[i].tone});
      chk($sformatf("tone_valid[%0d]", i), {15'd0, tone_valid}, {15'd0, tbl[i].valid});
      @(negedge clk);
      chk($sformatf("valid_pulse[%0d]", i), {15'd0, tone_valid}, 16'd0);
      idle(10);
    end

    // Busy held through two tone changes: only the latest byte goes out.
    force_busy = 1'b1;
    s = start_cnt;
    repeat (3) begin frame(16'd256, 16'd0); idle(10); end
    chk("busy_tone_bin0", {14'd0, tone}, 16'd1);
    repeat (3) begin frame(16'd0, 16'd0); idle(10); end
    chk("busy_tone_none", {14'd0, tone}, 16'd0);
    chk("busy_no_tx", 16'(start_cnt - s), 16'd0);
    exp_q.push_back(8'h2D);
    force_busy = 1'b0;
    idle(20);
    chk("busy_one_tx", 16'(start_cnt - s), 16'd1);

    // Reset while the feeder waits for busy to rise.
    uart_en = 1'b0;
    exp_q.push_back(8'h30);
    repeat (3) begin frame(16'd1000, 16'd100); idle(2); end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (tx_start) seen = 1'b1;
      else @(negedge clk);
    end
    chk("wait_hi_start_seen", {15'd0, seen}, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    g0 = 16'd1000; g1 = 16'd0; grdy = 1'b1;
    @(negedge clk);
    chk("midrst_tone", {14'd0, tone}, 16'd0);
    chk("midrst_tone_valid", {15'd0, tone_valid}, 16'd0);
    chk("midrst_tx_start", {15'd0, tx_start}, 16'd0);
    chk("midrst_tx_data", {8'd0, tx_data}, 16'd0);
    @(negedge clk);
    grdy = 1'b0;
    rst = 1'b0;
    uart_en = 1'b1;
    s = start_cnt;
    idle(30);
    chk("postrst_no_tx", 16'(start_cnt - s), 16'd0);
    chk("postrst_tone", {14'd0, tone}, 16'd0);
    exp_q.push_back(8'h31);
    repeat (3) begin frame(16'd100, 16'd1000); idle(10); end
    chk("postrst_tone_bin1", {14'd0, tone}, 16'd2);
    idle(10);
    chk("postrst_one_tx", 16'(start_cnt - s), 16'd1);
`endif

    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
